// File: rtl/gg_pkg.sv
// gg_pkg: shared constants and types for the gg_vectoring CORDIC vectoring unit.
//   Q_LEN_DEF / N_ITER_DEF : default datapath width and microrotation count
//   GROUP                  : microrotations emitted per output group
//   D_CW / D_CCW / D_SKIP  : direction codes carried on d1..d4
//   state_t                : controller states
package gg_pkg;

  localparam int Q_LEN_DEF  = 12;
  localparam int N_ITER_DEF = 12;
  localparam int GROUP      = 4;

  localparam logic [1:0] D_CW   = 2'd0;
  localparam logic [1:0] D_CCW  = 2'd1;
  localparam logic [1:0] D_SKIP = 2'd2;

  typedef enum logic {IDLE, RUN} state_t;

endpackage

// File: rtl/gg_vectoring_if.sv
// gg_vectoring_if: vector-in / group-out handshake bundle of gg_vectoring.
//   input side : in_valid, in_ready, xi, yi
//   output side: out_valid, out_ready, out_last, iter, d1..d4, neg, nop, xo
//   master = upstream/downstream environment, slave = the vectoring unit.
interface gg_vectoring_if #(
  parameter int Q_LEN = 12
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [Q_LEN-1:0] xi;
  logic signed [Q_LEN-1:0] yi;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;
  logic [3:0]              iter;
  logic [1:0]              d1;
  logic [1:0]              d2;
  logic [1:0]              d3;
  logic [1:0]              d4;
  logic                    neg;
  logic                    nop;
  logic signed [Q_LEN-1:0] xo;

  modport master (
    output in_valid, xi, yi, out_ready,
    input  in_ready, out_valid, out_last, iter, d1, d2, d3, d4, neg, nop, xo
  );

  modport slave (
    input  in_valid, xi, yi, out_ready,
    output in_ready, out_valid, out_last, iter, d1, d2, d3, d4, neg, nop, xo
  );
endinterface

// File: rtl/gg_micro_step.sv
// gg_micro_step: one combinational CORDIC vectoring microrotation.
//   x, y         : vector entering the step
//   shift        : iteration index i (shift amount)
//   dir          : decision taken (D_CW / D_CCW / D_SKIP)
//   x_nxt, y_nxt : rotated vector, wrap-around Q_LEN arithmetic
module gg_micro_step
  import gg_pkg::*;
#(
  parameter int Q_LEN = Q_LEN_DEF
) (
  input  logic signed [Q_LEN-1:0] x,
  input  logic signed [Q_LEN-1:0] y,
  input  logic [3:0]              shift,
  output logic [1:0]              dir,
  output logic signed [Q_LEN-1:0] x_nxt,
  output logic signed [Q_LEN-1:0] y_nxt
);

  logic signed [Q_LEN-1:0] x_sh;
  logic signed [Q_LEN-1:0] y_sh;

  assign x_sh = x >>> shift;
  assign y_sh = y >>> shift;

  always_comb begin
    dir   = D_SKIP;
    x_nxt = x;
    y_nxt = y;
    if (y == '0) begin
      dir = D_SKIP;
    end else if (y[Q_LEN-1]) begin
      dir   = D_CCW;
      x_nxt = x - y_sh;
      y_nxt = y + x_sh;
    end else begin
      dir   = D_CW;
      x_nxt = x + y_sh;
      y_nxt = y - x_sh;
    end
  end

endmodule

// File: rtl/gg_vectoring.sv
// gg_vectoring: multi-cycle CORDIC vectoring unit. Accepts (xi, yi), drives y
// toward zero and emits the microrotation decisions four at a time.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : gg_vectoring_if.slave (vector input, group output handshakes)
//
//   state | meaning
//   IDLE  | in_ready high, waiting to capture a vector
//   RUN   | presenting one group per handshake until out_last is accepted
module gg_vectoring
  import gg_pkg::*;
#(
  parameter int Q_LEN  = Q_LEN_DEF,
  parameter int R_FRAC = 2,
  parameter int N_ITER = N_ITER_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  gg_vectoring_if.slave  bus
);

  if ((N_ITER % GROUP) != 0 || N_ITER > 16 || N_ITER < GROUP || R_FRAC >= Q_LEN)
  begin : g_bad_param
    $error("gg_vectoring: illegal parameter combination");
  end

  state_t state_q, state_d;

  logic signed [Q_LEN-1:0] x_r, y_r;
  logic [3:0]              iter_r;
  logic                    neg_r, nop_r;

  logic signed [Q_LEN-1:0] xs [GROUP+1];
  logic signed [Q_LEN-1:0] ys [GROUP+1];
  logic [1:0]              dir [GROUP];

  logic                    last;
  logic                    xi_neg;
  logic signed [Q_LEN-1:0] x_in, y_in;

  assign xs[0] = x_r;
  assign ys[0] = y_r;

  for (genvar k = 0; k < GROUP; k++) begin : g_step
    gg_micro_step #(.Q_LEN(Q_LEN)) u_step (
      .x     (xs[k]),
      .y     (ys[k]),
      .shift (iter_r + 4'(k)),
      .dir   (dir[k]),
      .x_nxt (xs[k+1]),
      .y_nxt (ys[k+1])
    );
  end

  // Widened by one bit so that iter_r = 12 with N_ITER = 16 does not wrap.
  assign last = nop_r || (({1'b0, iter_r} + 5'(GROUP)) == 5'(N_ITER));

  // The vector is folded into the right half-plane before rotating; the
  // negation of the most negative code wraps, matching the datapath.
  assign xi_neg = bus.xi[Q_LEN-1];
  assign x_in   = xi_neg ? -bus.xi : bus.xi;
  assign y_in   = xi_neg ? -bus.yi : bus.yi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.iter      = 4'd0;
    bus.d1        = D_SKIP;
    bus.d2        = D_SKIP;
    bus.d3        = D_SKIP;
    bus.d4        = D_SKIP;
    bus.xo        = '0;
    bus.neg       = neg_r;
    bus.nop       = nop_r;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = RUN;
      end
      RUN: begin
        bus.out_valid = 1'b1;
        bus.out_last  = last;
        bus.iter      = iter_r;
        bus.d1        = dir[0];
        bus.d2        = dir[1];
        bus.d3        = dir[2];
        bus.d4        = dir[3];
        bus.xo        = xs[GROUP];
        if (bus.out_ready && last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r    <= '0;
      y_r    <= '0;
      iter_r <= 4'd0;
      neg_r  <= 1'b0;
      nop_r  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            x_r    <= x_in;
            y_r    <= y_in;
            iter_r <= 4'd0;
            neg_r  <= xi_neg;
            nop_r  <= (bus.yi == '0);
          end
        end
        RUN: begin
          if (bus.out_ready) begin
            if (last) begin
              x_r    <= '0;
              y_r    <= '0;
              iter_r <= 4'd0;
              neg_r  <= 1'b0;
              nop_r  <= 1'b0;
            end else begin
              x_r    <= xs[GROUP];
              y_r    <= ys[GROUP];
              iter_r <= iter_r + 4'(GROUP);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gg_vectoring.sv
module tb_gg_vectoring;

  localparam int Q_LEN  = 12;
  localparam int N_ITER = 12;

  logic clk;
  logic rst_n;

  gg_vectoring_if #(.Q_LEN(Q_LEN)) bus ();

  gg_vectoring #(.Q_LEN(Q_LEN), .R_FRAC(2), .N_ITER(N_ITER)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_fail  = 0;

  // Reference model results for the current vector.
  int exp_ng;
  int exp_iter [4];
  int exp_d    [4][4];
  int exp_xg   [4];
  int exp_yg   [4];
  int exp_xo;
  int exp_neg;
  int exp_nop;

  function automatic int wrap(input int v);
    logic signed [Q_LEN-1:0] t;
    t = v[Q_LEN-1:0];
    return int'(t);
  endfunction

  // Vectoring described directly from the rotation rules on integers.
  function automatic void model(input int xin, input int yin);
    int x, y, xn, yn, dd, g;
    exp_neg = (xin < 0) ? 1 : 0;
    exp_nop = (yin == 0) ? 1 : 0;
    x = exp_neg ? wrap(-xin) : xin;
    y = exp_neg ? wrap(-yin) : yin;
    for (int gi = 0; gi < 4; gi++) begin
      exp_iter[gi] = gi * 4;
      for (int j = 0; j < 4; j++) exp_d[gi][j] = 2;
    end
    if (exp_nop) begin
      exp_ng      = 1;
      exp_iter[0] = 0;
      exp_xo      = x;
      exp_xg[0]   = x;
      exp_yg[0]   = y;
      return;
    end
    exp_ng = N_ITER / 4;
    for (int i = 0; i < N_ITER; i++) begin
      g = i / 4;
      if (y == 0) begin
        dd = 2; xn = x; yn = y;
      end else if (y < 0) begin
        dd = 1; xn = wrap(x - (y >>> i)); yn = wrap(y + (x >>> i));
      end else begin
        dd = 0; xn = wrap(x + (y >>> i)); yn = wrap(y - (x >>> i));
      end
      exp_d[g][i % 4] = dd;
      x = xn;
      y = yn;
      if ((i % 4) == 3) begin
        exp_xg[g] = x;
        exp_yg[g] = y;
      end
    end
    exp_xo = x;
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    n_total++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_in_ready"},  bus.in_ready, 1);
    check({tag, "_out_last"},  bus.out_last, 0);
    check({tag, "_iter"},      bus.iter, 0);
    check({tag, "_d1"},        bus.d1, 2);
    check({tag, "_d2"},        bus.d2, 2);
    check({tag, "_d3"},        bus.d3, 2);
    check({tag, "_d4"},        bus.d4, 2);
    check({tag, "_neg"},       bus.neg, 0);
    check({tag, "_nop"},       bus.nop, 0);
    check({tag, "_xo"},        bus.xo, 0);
  endtask

  task automatic check_group(input int g);
    check("grp_out_valid", bus.out_valid, 1);
    check("grp_in_ready",  bus.in_ready, 0);
    check("grp_iter",      bus.iter, exp_iter[g]);
    check("grp_d1",        bus.d1, exp_d[g][0]);
    check("grp_d2",        bus.d2, exp_d[g][1]);
    check("grp_d3",        bus.d3, exp_d[g][2]);
    check("grp_d4",        bus.d4, exp_d[g][3]);
    check("grp_neg",       bus.neg, exp_neg);
    check("grp_nop",       bus.nop, exp_nop);
    check("grp_out_last",  bus.out_last, (g == exp_ng - 1) ? 1 : 0);
    if (g == exp_ng - 1) check("grp_xo", bus.xo, exp_xo);
  endtask

  task automatic start_vector(input int xv, input int yv);
    logic [31:0] xb, yb;
    xb = xv;
    yb = yv;
    model(xv, yv);
    check("cap_in_ready", bus.in_ready, 1);
    bus.xi       = xb[Q_LEN-1:0];
    bus.yi       = yb[Q_LEN-1:0];
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.xi       = Q_LEN'($urandom);
    bus.yi       = Q_LEN'($urandom);
  endtask

  task automatic run_vector(input int xv, input int yv, input int stall_g,
                            input int stall_n, input bit chk_int);
    start_vector(xv, yv);
    for (int g = 0; g < exp_ng; g++) begin
      check_group(g);
      if (g == stall_g) begin
        bus.out_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          bus.in_valid = 1'b1;
          bus.xi       = Q_LEN'($urandom);
          bus.yi       = Q_LEN'($urandom);
          @(posedge clk); #1;
          check_group(g);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
      end
      @(posedge clk); #1;
      if (chk_int && g < exp_ng - 1) begin
        check("int_x", dut.x_r, exp_xg[g]);
        check("int_y", dut.y_r, exp_yg[g]);
      end
    end
    check("end_out_valid", bus.out_valid, 0);
    check("end_in_ready",  bus.in_ready, 1);
  endtask

  initial begin
    int xv, yv, sg, sn;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.xi        = '0;
    bus.yi        = '0;
    #12;
    check_idle_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("post_rst");

    // Directed vectors from the plan.
    run_vector(100, -50, -1, 0, 1'b1);
    run_vector(256, 256, -1, 0, 1'b1);
    run_vector(-100, 50, -1, 0, 1'b1);
    run_vector(77, 0, -1, 0, 1'b0);
    run_vector(-77, 0, -1, 0, 1'b0);
    run_vector(-2048, 5, -1, 0, 1'b1);
    run_vector(2047, -2048, -1, 0, 1'b1);

    // Stall on group iter=4 with in_valid pulses during the stall.
    run_vector(100, -50, 1, 5, 1'b1);

    // Reset in the middle of a vector.
    start_vector(100, -50);
    check_group(0);
    @(posedge clk); #1;
    check("mid_iter_before_rst", bus.iter, 4);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", bus.out_valid, 0);
    check("rst_mid_in_ready",  bus.in_ready, 1);
    check("rst_mid_iter",      bus.iter, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("after_mid_rst");
    run_vector(100, -50, -1, 0, 1'b1);

    // Randomized vectors with occasional stalls.
    for (int n = 0; n < 30; n++) begin
      xv = wrap(int'($urandom_range(0, 4095)));
      yv = ($urandom_range(0, 5) == 0) ? 0 : wrap(int'($urandom_range(0, 4095)));
      sg = int'($urandom_range(0, 3)) - 1;
      sn = int'($urandom_range(1, 4));
      run_vector(xv, yv, sg, sn, 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
